// File: rtl/uart_control_module.sv
// ----------------------------------------------------------------------------
// uart_control_module
//
// Purpose:
//   Receives an 8N1 byte stream on a UART line and decodes it into display
//   control commands for the LED panel driver.
//   - 'R' <arg>           : colour-plane enables  <= arg[2:0]
//   - 'b' <arg>           : brightness enables    <= arg[5:0]
//   - 'L' <row> <128 x d> : writes one pixel row into the frame RAM
//
// Parameters:
//   UART_CLK_TICKS_PER_BIT : clk_in cycles per UART bit
//   UART_CLK_TICKS_WIDTH   : width of the bit-tick counter
//
// Ports:
//   clk_in            : system clock, rising edge
//   reset             : asynchronous, active-low reset
//   uart_rx           : serial input, idle high, LSB first
//   rx_running        : high from start-bit detection to stop-bit sample
//   rgb_enable        : colour-plane enables {B,G,R}
//   brightness_enable : brightness bit-plane enables
//   ram_data_out      : frame RAM write data
//   ram_address       : frame RAM write address {row, byte_index}
//   ram_write_enable  : one-cycle write strobe
//   ram_clk_enable    : RAM clock enable, mirrors the write strobe
//   ram_reset         : active-high RAM reset (inverse of reset)
//   cmd_line_state2   : command FSM state code
// ----------------------------------------------------------------------------
module uart_control_module #(
    parameter int UART_CLK_TICKS_PER_BIT = 9,
    parameter int UART_CLK_TICKS_WIDTH   = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        rx_running,
    output logic [2:0]  rgb_enable,
    output logic [5:0]  brightness_enable,
    output logic [7:0]  ram_data_out,
    output logic [11:0] ram_address,
    output logic        ram_write_enable,
    output logic        ram_clk_enable,
    output logic        ram_reset,
    output logic [1:0]  cmd_line_state2
);

    // Tick counter terminal values: the start bit is checked half a bit
    // after detection, every later sample is one full bit further on.
    localparam logic [UART_CLK_TICKS_WIDTH-1:0] HALF_BIT_LAST =
        UART_CLK_TICKS_WIDTH'(UART_CLK_TICKS_PER_BIT / 2 - 1);
    localparam logic [UART_CLK_TICKS_WIDTH-1:0] FULL_BIT_LAST =
        UART_CLK_TICKS_WIDTH'(UART_CLK_TICKS_PER_BIT - 1);

    localparam logic [7:0] OPCODE_RGB    = 8'h52;  // 'R'
    localparam logic [7:0] OPCODE_BRIGHT = 8'h62;  // 'b'
    localparam logic [7:0] OPCODE_ROW    = 8'h4C;  // 'L'

    localparam logic [6:0] LAST_BYTE_INDEX = 7'd127;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_ARG  = 2'd1,
        CMD_DATA = 2'd2
    } cmd_state_t;

    typedef enum logic [1:0] {
        ARG_RGB    = 2'd0,
        ARG_BRIGHT = 2'd1,
        ARG_ROW    = 2'd2
    } arg_kind_t;

    // Receiver signals
    logic                            rx_sync1;
    logic                            rx_sync2;
    rx_state_t                       rx_state;
    logic [UART_CLK_TICKS_WIDTH-1:0] tick_count;
    logic [2:0]                      bit_count;
    logic [7:0]                      shift_reg;
    logic [7:0]                      rx_byte;
    logic                            byte_valid;

    // Command decoder signals
    cmd_state_t cmd_state;
    arg_kind_t  arg_kind;
    logic [4:0] row;
    logic [6:0] byte_index;

    // The RAM is held in reset whenever this block is.
    assign ram_reset       = ~reset;
    assign cmd_line_state2 = cmd_state;

    // Two-flop synchroniser; resets to the idle-high line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
        end
    end

    // UART receiver. A low line in idle starts a frame; the start bit is
    // re-checked at its midpoint to reject glitches, then data and stop bits
    // are sampled at their midpoints. The receiver returns to idle at the
    // stop-bit sample, so a start bit directly following the stop bit is
    // picked up without any idle gap. Frames with a low stop bit are
    // silently dropped.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            tick_count <= '0;
            bit_count  <= '0;
            shift_reg  <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            rx_running <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync2) begin
                        rx_state   <= RX_START;
                        tick_count <= '0;
                        rx_running <= 1'b1;
                    end
                end
                RX_START: begin
                    if (tick_count == HALF_BIT_LAST) begin
                        tick_count <= '0;
                        if (rx_sync2) begin
                            rx_state   <= RX_IDLE;
                            rx_running <= 1'b0;
                        end else begin
                            rx_state  <= RX_DATA;
                            bit_count <= '0;
                        end
                    end else begin
                        tick_count <= tick_count + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_count == FULL_BIT_LAST) begin
                        tick_count <= '0;
                        shift_reg  <= {rx_sync2, shift_reg[7:1]};
                        bit_count  <= bit_count + 1'b1;
                        if (bit_count == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        tick_count <= tick_count + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_count == FULL_BIT_LAST) begin
                        tick_count <= '0;
                        rx_state   <= RX_IDLE;
                        rx_running <= 1'b0;
                        if (rx_sync2) begin
                            rx_byte    <= shift_reg;
                            byte_valid <= 1'b1;
                        end
                    end else begin
                        tick_count <= tick_count + 1'b1;
                    end
                end
                default: begin
                    rx_state   <= RX_IDLE;
                    rx_running <= 1'b0;
                end
            endcase
        end
    end

    // Command decoder. Only acts on cycles with a freshly received byte.
    // Outside IDLE every byte is payload, so opcode values are not
    // interpreted there. The RAM address/data registers keep their last
    // value between writes; only the strobes are cleared every cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cmd_state         <= CMD_IDLE;
            arg_kind          <= ARG_RGB;
            row               <= '0;
            byte_index        <= '0;
            rgb_enable        <= 3'b111;
            brightness_enable <= 6'b111111;
            ram_data_out      <= '0;
            ram_address       <= '0;
            ram_write_enable  <= 1'b0;
            ram_clk_enable    <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            ram_clk_enable   <= 1'b0;
            if (byte_valid) begin
                case (cmd_state)
                    CMD_ARG: begin
                        case (arg_kind)
                            ARG_RGB: begin
                                rgb_enable <= rx_byte[2:0];
                                cmd_state  <= CMD_IDLE;
                            end
                            ARG_BRIGHT: begin
                                brightness_enable <= rx_byte[5:0];
                                cmd_state         <= CMD_IDLE;
                            end
                            ARG_ROW: begin
                                row        <= rx_byte[4:0];
                                byte_index <= '0;
                                cmd_state  <= CMD_DATA;
                            end
                            default: begin
                                cmd_state <= CMD_IDLE;
                            end
                        endcase
                    end
                    CMD_DATA: begin
                        ram_data_out     <= rx_byte;
                        ram_address      <= {row, byte_index};
                        ram_write_enable <= 1'b1;
                        ram_clk_enable   <= 1'b1;
                        // The index stops at 127 rather than wrapping; the
                        // FSM leaves DATA on that final write.
                        if (byte_index == LAST_BYTE_INDEX) begin
                            cmd_state <= CMD_IDLE;
                        end else begin
                            byte_index <= byte_index + 1'b1;
                        end
                    end
                    // IDLE and the unused code 3 both decode opcodes.
                    default: begin
                        cmd_state <= CMD_IDLE;
                        case (rx_byte)
                            OPCODE_RGB: begin
                                arg_kind  <= ARG_RGB;
                                cmd_state <= CMD_ARG;
                            end
                            OPCODE_BRIGHT: begin
                                arg_kind  <= ARG_BRIGHT;
                                cmd_state <= CMD_ARG;
                            end
                            OPCODE_ROW: begin
                                arg_kind  <= ARG_ROW;
                                cmd_state <= CMD_ARG;
                            end
                            default: begin
                                cmd_state <= CMD_IDLE;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_control_module.sv
// ----------------------------------------------------------------------------
// tb_uart_control_module
//
// Purpose:
//   Directed self-checking bench for uart_control_module. Drives 8N1 frames
//   on uart_rx and compares outputs with hand-computed values. A passive
//   monitor logs RAM write strobes, rx_running pulses and FSM state changes
//   for later comparison.
// ----------------------------------------------------------------------------
module tb_uart_control_module;

    localparam int TICKS = 9;

    logic        tb_clk_baudrate = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        rx_running;
    logic [2:0]  rgb_enable;
    logic [5:0]  brightness_enable;
    logic [7:0]  ram_data_out;
    logic [11:0] ram_address;
    logic        ram_write_enable;
    logic        ram_clk_enable;
    logic        ram_reset;
    logic [1:0]  cmd_line_state2;

    int checks = 0;
    int errors = 0;

    // Monitor bookkeeping
    logic [11:0] log_addr [0:511];
    logic [7:0]  log_data [0:511];
    int          write_count    = 0;
    int          strobe_run     = 0;
    int          max_strobe_run = 0;
    int          en_mismatch    = 0;
    int          running_pulses = 0;
    logic        prev_running   = 1'b0;
    int          prev_state     = 0;
    int          state_log[$];

    uart_control_module #(
        .UART_CLK_TICKS_PER_BIT(9),
        .UART_CLK_TICKS_WIDTH(4)
    ) dut (
        .clk_in(tb_clk_baudrate),
        .reset(reset),
        .uart_rx(uart_rx),
        .rx_running(rx_running),
        .rgb_enable(rgb_enable),
        .brightness_enable(brightness_enable),
        .ram_data_out(ram_data_out),
        .ram_address(ram_address),
        .ram_write_enable(ram_write_enable),
        .ram_clk_enable(ram_clk_enable),
        .ram_reset(ram_reset),
        .cmd_line_state2(cmd_line_state2)
    );

    always #5 tb_clk_baudrate = ~tb_clk_baudrate;

    // Passive monitor, sampled on the falling edge.
    always @(negedge tb_clk_baudrate) begin
        if (ram_write_enable === 1'b1) begin
            if (write_count < 512) begin
                log_addr[write_count] = ram_address;
                log_data[write_count] = ram_data_out;
            end
            write_count = write_count + 1;
            strobe_run  = strobe_run + 1;
            if (strobe_run > max_strobe_run) max_strobe_run = strobe_run;
        end else begin
            strobe_run = 0;
        end
        if (ram_clk_enable !== ram_write_enable) en_mismatch = en_mismatch + 1;
        if (rx_running === 1'b1 && prev_running === 1'b0) running_pulses = running_pulses + 1;
        prev_running = rx_running;
        if (int'(cmd_line_state2) != prev_state) begin
            state_log.push_back(int'(cmd_line_state2));
            prev_state = int'(cmd_line_state2);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge tb_clk_baudrate);
    endtask

    // One 8N1 frame; stop_bit = 0 produces a framing error.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
        uart_rx = 1'b0;
        idle_cycles(TICKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            idle_cycles(TICKS);
        end
        uart_rx = stop_bit;
        idle_cycles(TICKS);
        uart_rx = 1'b1;
    endtask

    function automatic logic [7:0] row_byte(input int k);
        return 8'h38 - 8'((k / 2) % 8);
    endfunction

    initial begin
        int base_writes;
        int base_pulses;
        int log_start;

        // Reset state
        reset   = 1'b0;
        uart_rx = 1'b1;
        idle_cycles(3);
        $display("[TB] checking reset state");
        check_output("rst_rgb", 32'(rgb_enable), 32'h7);
        check_output("rst_bright", 32'(brightness_enable), 32'h3F);
        check_output("rst_state", 32'(cmd_line_state2), 32'h0);
        check_output("rst_we", 32'(ram_write_enable), 32'h0);
        check_output("rst_ram_reset", 32'(ram_reset), 32'h1);
        check_output("rst_running", 32'(rx_running), 32'h0);
        check_output("rst_addr", 32'(ram_address), 32'h0);
        check_output("rst_data", 32'(ram_data_out), 32'h0);
        reset = 1'b1;
        idle_cycles(1);
        check_output("ram_reset_released", 32'(ram_reset), 32'h0);
        idle_cycles(20);

        // Brightness command 'b' 'r'
        $display("[TB] brightness command");
        apply_stimulus(8'h62, 1'b1);
        idle_cycles(4);
        check_output("bright_arg_state", 32'(cmd_line_state2), 32'h1);
        apply_stimulus(8'h72, 1'b1);
        idle_cycles(4);
        check_output("bright_value", 32'(brightness_enable), 32'h32);
        check_output("bright_state", 32'(cmd_line_state2), 32'h0);
        check_output("bright_rgb_kept", 32'(rgb_enable), 32'h7);

        // Colour command 'R' ' '
        $display("[TB] colour command");
        apply_stimulus(8'h52, 1'b1);
        apply_stimulus(8'h20, 1'b1);
        idle_cycles(4);
        check_output("rgb_value", 32'(rgb_enable), 32'h0);
        check_output("rgb_bright_kept", 32'(brightness_enable), 32'h32);
        check_output("rgb_state", 32'(cmd_line_state2), 32'h0);

        // Row write 'L' '-' + 128 back-to-back data bytes
        $display("[TB] row write");
        base_writes = write_count;
        log_start   = state_log.size();
        apply_stimulus(8'h4C, 1'b1);
        apply_stimulus(8'h2D, 1'b1);
        for (int k = 0; k < 128; k++) begin
            apply_stimulus(row_byte(k), 1'b1);
        end
        idle_cycles(6);
        check_output("row_write_count", 32'(write_count - base_writes), 32'd128);
        check_output("row_strobe_width", 32'(max_strobe_run), 32'd1);
        check_output("row_clk_en_match", 32'(en_mismatch), 32'd0);
        check_output("row_first_data", 32'(log_data[base_writes]), 32'h38);
        for (int k = 0; k < 128; k++) begin
            check_output($sformatf("row_addr_%0d", k), 32'(log_addr[base_writes + k]), 32'h680 + 32'(k));
            check_output($sformatf("row_data_%0d", k), 32'(log_data[base_writes + k]), 32'(row_byte(k)));
        end
        check_output("row_state_changes", 32'(state_log.size() - log_start), 32'd3);
        if (state_log.size() - log_start >= 3) begin
            check_output("row_state_seq0", 32'(state_log[log_start]), 32'd1);
            check_output("row_state_seq1", 32'(state_log[log_start + 1]), 32'd2);
            check_output("row_state_seq2", 32'(state_log[log_start + 2]), 32'd0);
        end
        check_output("row_end_state", 32'(cmd_line_state2), 32'h0);
        check_output("row_addr_hold", 32'(ram_address), 32'h6FF);
        check_output("row_data_hold", 32'(ram_data_out), 32'(row_byte(127)));
        check_output("row_we_low", 32'(ram_write_enable), 32'h0);

        // Framing error in IDLE on an opcode value
        $display("[TB] framing error");
        base_writes = write_count;
        base_pulses = running_pulses;
        apply_stimulus(8'h62, 1'b0);
        idle_cycles(12 * TICKS);
        check_output("frame_running_pulsed", 32'(running_pulses > base_pulses), 32'h1);
        check_output("frame_state", 32'(cmd_line_state2), 32'h0);
        check_output("frame_no_write", 32'(write_count - base_writes), 32'd0);
        check_output("frame_bright_kept", 32'(brightness_enable), 32'h32);
        apply_stimulus(8'h52, 1'b1);
        apply_stimulus(8'h05, 1'b1);
        idle_cycles(4);
        check_output("frame_next_cmd_rgb", 32'(rgb_enable), 32'h5);
        check_output("frame_next_cmd_bright", 32'(brightness_enable), 32'h32);

        // Glitch shorter than half a bit
        $display("[TB] start-bit glitch");
        base_writes = write_count;
        base_pulses = running_pulses;
        uart_rx = 1'b0;
        idle_cycles(2);
        uart_rx = 1'b1;
        idle_cycles(2);
        check_output("glitch_running_high", 32'(rx_running), 32'h1);
        idle_cycles(10);
        check_output("glitch_running_low", 32'(rx_running), 32'h0);
        check_output("glitch_pulses", 32'(running_pulses - base_pulses), 32'd1);
        check_output("glitch_state", 32'(cmd_line_state2), 32'h0);
        check_output("glitch_no_write", 32'(write_count - base_writes), 32'd0);

        // Reset in the middle of a row
        $display("[TB] reset mid-row");
        apply_stimulus(8'h4C, 1'b1);
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'hAA, 1'b1);
        apply_stimulus(8'hBB, 1'b1);
        apply_stimulus(8'hCC, 1'b1);
        idle_cycles(4);
        check_output("midrow_state", 32'(cmd_line_state2), 32'h2);
        check_output("midrow_addr", 32'(ram_address), 32'h082);
        check_output("midrow_data", 32'(ram_data_out), 32'hCC);
        reset = 1'b0;
        idle_cycles(1);
        check_output("midrow_rst_state", 32'(cmd_line_state2), 32'h0);
        check_output("midrow_rst_rgb", 32'(rgb_enable), 32'h7);
        check_output("midrow_rst_addr", 32'(ram_address), 32'h0);
        check_output("midrow_rst_ram_reset", 32'(ram_reset), 32'h1);
        reset = 1'b1;
        idle_cycles(5);
        apply_stimulus(8'h62, 1'b1);
        apply_stimulus(8'h01, 1'b1);
        idle_cycles(4);
        check_output("after_rst_bright", 32'(brightness_enable), 32'h01);
        check_output("after_rst_state", 32'(cmd_line_state2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
